decode_queue: RTL and testbench
===============================

// Module: decode_queue
// PURPOSE
//  Parametrised decoded-instruction queue between instruction decode and dispatch (RS/ROB allocate).
//  Replaces the single decode output register with a DEPTH-entry circular buffer using valid/ready handshakes.
//  Each queued entry snoops the CDB, so a source operand that was busy at decode becomes ready while the entry waits.
//  The whole queue is cleared by flush on a misprediction or misdirect.
// PARAMETERS
//  WIDTH   31  msb index of the operand/result datapath (data is WIDTH+1 bits)
//  ROB     2   msb index of a ROB tag (tags are ROB+1 bits)
//  CTRL_W  32  width of the packed control bundle (pc, immExt, ALUControl, RSstation, flags, destRegW, regStatusSnap)
//  DEPTH   4   number of entries; power of two, >= 2
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           synchronous, active-high; clears queue
//  flush      in   1           synchronous; misprediction/misdirect clear (same effect as reset)
//  inValid    in   1           decode presents an entry
//  inReady    out  1           queue can accept an entry
//  inCtrl     in   CTRL_W      control bundle, stored verbatim
//  inOp1      in   WIDTH+1     operand 1 value (from the register file)
//  inOp2      in   WIDTH+1     operand 2 value (register-file value or extended immediate)
//  inBusy1    in   1           operand 1 awaits ROB tag inRob1
//  inBusy2    in   1           operand 2 awaits ROB tag inRob2 (0 when the immediate is used)
//  inRob1     in   ROB+1       source tag for operand 1
//  inRob2     in   ROB+1       source tag for operand 2
//  cdbValid   in   1           CDB broadcast this cycle
//  cdbROB     in   ROB+1       broadcasting ROB tag
//  cdbResult  in   WIDTH+1     broadcast value
//  outValid   out  1           head entry valid
//  outReady   in   1           dispatch accepts (driven !fullRob)
//  outCtrl/outOp1/outOp2/outBusy1/outBusy2/outRob1/outRob2  out  as in*  head entry fields
//  count      out  $clog2(DEPTH)+1  number of occupied entries
// BEHAVIOUR
//  - Reset (priority 1) or flush (priority 2): count=0, head=tail=0, all busy bits and storage cleared.
//    An enqueue or dequeue in the same cycle is discarded.
//    After reset: outValid=0, inReady=1, count=0, all out* data=0.
//  - inReady = (count != DEPTH). No bypass when full: a same-cycle dequeue does not raise inReady.
//  - enq = inValid & inReady: write the entry at tail, then tail <= tail+1 (wraps modulo DEPTH).
//  - deq = outValid & outReady: head <= head+1 (wraps modulo DEPTH).
//  - count <= count + enq - deq. Simultaneous enq and deq leaves count unchanged.
//    Legal when count=0? No: outValid=0, so there is no deq.
//  - Latency: an entry enqueued in cycle N is at the output in N+1 at the earliest. There is no empty-queue flow-through.
//  - outValid = (count != 0). All out* fields are driven 0 when outValid=0.
//  - CDB snoop on stored entries: every valid entry with cdbValid & busyK & robK==cdbROB
//    gets opK <= cdbResult and busyK <= 0 at the clock edge (K=1,2 independently; both may match).
//  - CDB snoop on the write port: if an enqueuing entry has inBusyK & inRobK==cdbROB & cdbValid,
//    it is stored with opK=cdbResult and busyK=0.
//  - Output forwarding is combinational. If the head has busyK and matches the CDB this cycle,
//    then outOpK=cdbResult and outBusyK=0. This covers a dispatch that coincides with the broadcast.
//  - When busyK=0 the tag is ignored. An entry is never matched by a tag while its busy bit is clear.
//  - No rearrangement: entries dispatch strictly in program (FIFO) order.
// TESTING
//  1. Reset, then enqueue 3 entries with outReady=0 -> count=3, outValid=1, head = first entry.
//     Raise outReady -> entries dispatch in order over 3 cycles, then outValid=0.
//  2. Fill to DEPTH=4 -> inReady=0. Hold inValid=1 for 2 cycles -> no write, count stays 4.
//     Dequeue 1 -> inReady=1 next cycle.
//  3. Queue entry with inBusy1=1, inRob1=5; later cdbValid=1, cdbROB=5, cdbResult=32'hDEAD_BEEF
//     -> next cycle outOp1=32'hDEAD_BEEF, outBusy1=0. A broadcast with tag 4 leaves the entry untouched.
//  4. Head has busy2, rob2=3; in the same cycle cdbValid=1, cdbROB=3, result=7, with outReady=1
//     -> the dispatched outOp2=7, outBusy2=0.
//  5. count=3, assert flush together with inValid=1 -> next cycle count=0, outValid=0, nothing written.
//     Also assert reset in the middle of a fill -> same result.
//  6. Run 3*DEPTH enqueues and dequeues back to back (enq & deq every cycle) -> count constant,
//     pointers wrap, order preserved, no lost or duplicated entries.

Source files
------------

// File: rtl/decode_queue_if.sv
// Decode-to-dispatch queue bundle: enqueue side, CDB snoop inputs and dequeue side.
// Latency: none; pure signal grouping.
// Backpressure: inReady/outReady carry the valid-ready handshakes in each direction.
// Ports: enqueue (inValid/inReady/in*), CDB (cdbValid/cdbROB/cdbResult),
//        dequeue (outValid/outReady/out*), occupancy (count).
// slave modport is the queue itself; master modport is the decode/dispatch/CDB environment.
interface decode_queue_if #(
    parameter int WIDTH  = 31,
    parameter int ROB    = 2,
    parameter int CTRL_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              inValid;
    logic              inReady;
    logic [CTRL_W-1:0] inCtrl;
    logic [WIDTH:0]    inOp1;
    logic [WIDTH:0]    inOp2;
    logic              inBusy1;
    logic              inBusy2;
    logic [ROB:0]      inRob1;
    logic [ROB:0]      inRob2;

    logic              cdbValid;
    logic [ROB:0]      cdbROB;
    logic [WIDTH:0]    cdbResult;

    logic              outValid;
    logic              outReady;
    logic [CTRL_W-1:0] outCtrl;
    logic [WIDTH:0]    outOp1;
    logic [WIDTH:0]    outOp2;
    logic              outBusy1;
    logic              outBusy2;
    logic [ROB:0]      outRob1;
    logic [ROB:0]      outRob2;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  inValid, inCtrl, inOp1, inOp2, inBusy1, inBusy2, inRob1, inRob2,
        input  cdbValid, cdbROB, cdbResult,
        input  outReady,
        output inReady,
        output outValid, outCtrl, outOp1, outOp2, outBusy1, outBusy2, outRob1, outRob2,
        output count
    );

    modport master (
        output inValid, inCtrl, inOp1, inOp2, inBusy1, inBusy2, inRob1, inRob2,
        output cdbValid, cdbROB, cdbResult,
        output outReady,
        input  inReady,
        input  outValid, outCtrl, outOp1, outOp2, outBusy1, outBusy2, outRob1, outRob2,
        input  count
    );
endinterface

// File: rtl/decode_queue.sv
// Decoded-instruction circular queue between decode and dispatch; entries snoop the CDB while waiting.
// Latency: 1 cycle enqueue-to-output (no empty flow-through); head operands forwarded combinationally from the CDB.
// Backpressure: inReady = not full (no same-cycle dequeue bypass); head held while outReady is low.
// Ports: clk, reset (sync, active-high), flush (sync clear), dq (decode_queue_if.slave: enqueue, CDB, dequeue, count).
module decode_queue #(
    parameter int WIDTH  = 31,
    parameter int ROB    = 2,
    parameter int CTRL_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    decode_queue_if.slave  dq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic [WIDTH:0]    op1_q   [DEPTH];
    logic [WIDTH:0]    op1_d   [DEPTH];
    logic [WIDTH:0]    op2_q   [DEPTH];
    logic [WIDTH:0]    op2_d   [DEPTH];
    logic [ROB:0]      rob1_q  [DEPTH];
    logic [ROB:0]      rob1_d  [DEPTH];
    logic [ROB:0]      rob2_q  [DEPTH];
    logic [ROB:0]      rob2_d  [DEPTH];
    logic [DEPTH-1:0]  busy1_q, busy1_d;
    logic [DEPTH-1:0]  busy2_q, busy2_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              enq;
    logic              deq;
    logic              in_rdy;
    logic              out_vld;
    logic              wr_hit1;
    logic              wr_hit2;
    logic [DEPTH-1:0]  slot_vld;

    assign in_rdy  = (count_q != CNT_W'(DEPTH));
    assign out_vld = (count_q != '0);
    assign enq     = dq.inValid & in_rdy;
    assign deq     = out_vld & dq.outReady;

    // Write-port snoop: an operand whose producer broadcasts in the enqueue cycle is captured directly.
    assign wr_hit1 = dq.cdbValid & dq.inBusy1 & (dq.inRob1 == dq.cdbROB);
    assign wr_hit2 = dq.cdbValid & dq.inBusy2 & (dq.inRob2 == dq.cdbROB);

    // A slot is occupied when its distance from head (mod DEPTH) is below the occupancy.
    always_comb begin
        slot_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = CNT_W'(PTR_W'(PTR_W'(i) - head_q)) < count_q;
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        rob1_d  = rob1_q;
        rob2_d  = rob2_q;
        busy1_d = busy1_q;
        busy2_d = busy2_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

        // Stored-entry snoop; the tail slot is never occupied when enq fires, so the write below cannot collide.
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && dq.cdbValid) begin
                if (busy1_q[i] && (rob1_q[i] == dq.cdbROB)) begin
                    op1_d[i]   = dq.cdbResult;
                    busy1_d[i] = 1'b0;
                end
                if (busy2_q[i] && (rob2_q[i] == dq.cdbROB)) begin
                    op2_d[i]   = dq.cdbResult;
                    busy2_d[i] = 1'b0;
                end
            end
        end

        if (enq) begin
            ctrl_d[tail_q]  = dq.inCtrl;
            op1_d[tail_q]   = wr_hit1 ? dq.cdbResult : dq.inOp1;
            op2_d[tail_q]   = wr_hit2 ? dq.cdbResult : dq.inOp2;
            busy1_d[tail_q] = dq.inBusy1 & ~wr_hit1;
            busy2_d[tail_q] = dq.inBusy2 & ~wr_hit2;
            rob1_d[tail_q]  = dq.inRob1;
            rob2_d[tail_q]  = dq.inRob2;
            tail_d          = tail_q + PTR_W'(1);
        end

        if (deq) begin
            head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                op1_q[i]  <= '0;
                op2_q[i]  <= '0;
                rob1_q[i] <= '0;
                rob2_q[i] <= '0;
            end
            busy1_q <= '0;
            busy2_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            rob1_q  <= rob1_d;
            rob2_q  <= rob2_d;
            busy1_q <= busy1_d;
            busy2_q <= busy2_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head output with combinational CDB forwarding so a dispatch coinciding with the broadcast sees the value.
    logic [CTRL_W-1:0] out_ctrl;
    logic [WIDTH:0]    out_op1, out_op2;
    logic              out_busy1, out_busy2;
    logic [ROB:0]      out_rob1, out_rob2;
    logic              fwd1, fwd2;

    always_comb begin
        out_ctrl  = '0;
        out_op1   = '0;
        out_op2   = '0;
        out_busy1 = 1'b0;
        out_busy2 = 1'b0;
        out_rob1  = '0;
        out_rob2  = '0;
        fwd1      = 1'b0;
        fwd2      = 1'b0;
        if (out_vld) begin
            fwd1      = dq.cdbValid & busy1_q[head_q] & (rob1_q[head_q] == dq.cdbROB);
            fwd2      = dq.cdbValid & busy2_q[head_q] & (rob2_q[head_q] == dq.cdbROB);
            out_ctrl  = ctrl_q[head_q];
            out_op1   = fwd1 ? dq.cdbResult : op1_q[head_q];
            out_op2   = fwd2 ? dq.cdbResult : op2_q[head_q];
            out_busy1 = busy1_q[head_q] & ~fwd1;
            out_busy2 = busy2_q[head_q] & ~fwd2;
            out_rob1  = rob1_q[head_q];
            out_rob2  = rob2_q[head_q];
        end
    end

    assign dq.inReady  = in_rdy;
    assign dq.outValid = out_vld;
    assign dq.outCtrl  = out_ctrl;
    assign dq.outOp1   = out_op1;
    assign dq.outOp2   = out_op2;
    assign dq.outBusy1 = out_busy1;
    assign dq.outBusy2 = out_busy2;
    assign dq.outRob1  = out_rob1;
    assign dq.outRob2  = out_rob2;
    assign dq.count    = count_q;
endmodule

// File: tb/tb_decode_queue.sv
module tb_decode_queue;
    localparam int WIDTH  = 31;
    localparam int ROB    = 2;
    localparam int CTRL_W = 32;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mdl_on = 1'b0;

    decode_queue_if #(.WIDTH(WIDTH), .ROB(ROB), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dq ();

    decode_queue #(.WIDTH(WIDTH), .ROB(ROB), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .dq    (dq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [WIDTH:0]    op1;
        logic [WIDTH:0]    op2;
        logic              b1;
        logic              b2;
        logic [ROB:0]      r1;
        logic [ROB:0]      r2;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue; CDB matches rewrite waiting operands, the head shows forwarded values.
    always @(negedge clk) begin
        if (mdl_on) begin
            ent_t h;
            ent_t ne;
            bit   m_enq;
            bit   m_deq;
            h = '{default: '0};
            if (mq.size() != 0) begin
                h = mq[0];
                if (dq.cdbValid && h.b1 && h.r1 == dq.cdbROB) begin h.op1 = dq.cdbResult; h.b1 = 1'b0; end
                if (dq.cdbValid && h.b2 && h.r2 == dq.cdbROB) begin h.op2 = dq.cdbResult; h.b2 = 1'b0; end
            end
            chk("m_count",    dq.count,    mq.size());
            chk("m_outValid", dq.outValid, mq.size() != 0);
            chk("m_inReady",  dq.inReady,  mq.size() != DEPTH);
            chk("m_outCtrl",  dq.outCtrl,  h.ctrl);
            chk("m_outOp1",   dq.outOp1,   h.op1);
            chk("m_outOp2",   dq.outOp2,   h.op2);
            chk("m_outBusy1", dq.outBusy1, h.b1);
            chk("m_outBusy2", dq.outBusy2, h.b2);
            chk("m_outRob1",  dq.outRob1,  mq.size() != 0 ? h.r1 : '0);
            chk("m_outRob2",  dq.outRob2,  mq.size() != 0 ? h.r2 : '0);

            if (reset || flush) begin
                mq.delete();
            end else begin
                m_enq = dq.inValid && (mq.size() < DEPTH);
                m_deq = (mq.size() != 0) && dq.outReady;
                foreach (mq[i]) begin
                    if (dq.cdbValid && mq[i].b1 && mq[i].r1 == dq.cdbROB) begin mq[i].op1 = dq.cdbResult; mq[i].b1 = 1'b0; end
                    if (dq.cdbValid && mq[i].b2 && mq[i].r2 == dq.cdbROB) begin mq[i].op2 = dq.cdbResult; mq[i].b2 = 1'b0; end
                end
                if (m_deq) void'(mq.pop_front());
                if (m_enq) begin
                    ne.ctrl = dq.inCtrl;
                    ne.r1   = dq.inRob1;
                    ne.r2   = dq.inRob2;
                    ne.op1  = dq.inOp1;
                    ne.op2  = dq.inOp2;
                    ne.b1   = dq.inBusy1;
                    ne.b2   = dq.inBusy2;
                    if (dq.cdbValid && ne.b1 && ne.r1 == dq.cdbROB) begin ne.op1 = dq.cdbResult; ne.b1 = 1'b0; end
                    if (dq.cdbValid && ne.b2 && ne.r2 == dq.cdbROB) begin ne.op2 = dq.cdbResult; ne.b2 = 1'b0; end
                    mq.push_back(ne);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] c, input logic [31:0] o1, input logic [31:0] o2,
                       input logic b1, input logic b2, input logic [2:0] r1, input logic [2:0] r2);
        dq.inValid = 1'b1;
        dq.inCtrl  = c;
        dq.inOp1   = o1;
        dq.inOp2   = o2;
        dq.inBusy1 = b1;
        dq.inBusy2 = b2;
        dq.inRob1  = r1;
        dq.inRob2  = r2;
    endtask

    task automatic idle_in();
        dq.inValid = 1'b0;
        dq.inBusy1 = 1'b0;
        dq.inBusy2 = 1'b0;
    endtask

    task automatic cdb(input logic v, input logic [2:0] tag, input logic [31:0] res);
        dq.cdbValid  = v;
        dq.cdbROB    = tag;
        dq.cdbResult = res;
    endtask

    initial begin
        put(0, 0, 0, 0, 0, 0, 0);
        idle_in();
        cdb(0, 0, 0);
        dq.outReady = 1'b0;

        // Reset state
        tick();
        mdl_on = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_count", dq.count, 0);
        chk("rst_outValid", dq.outValid, 0);
        chk("rst_inReady", dq.inReady, 1);
        chk("rst_outOp1", dq.outOp1, 0);
        chk("rst_outCtrl", dq.outCtrl, 0);

        // 1: enqueue 3 held, then in-order dispatch
        tick();
        put(1, 32'h101, 32'h201, 0, 0, 0, 0); tick();
        put(2, 32'h102, 32'h202, 0, 0, 0, 0); tick();
        put(3, 32'h103, 32'h203, 0, 0, 0, 0); tick();
        idle_in();
        @(negedge clk);
        chk("t1_count3", dq.count, 3);
        chk("t1_valid", dq.outValid, 1);
        chk("t1_head", dq.outCtrl, 1);
        tick();
        dq.outReady = 1'b1;
        @(negedge clk); chk("t1_deq1", dq.outCtrl, 1);
        tick();
        @(negedge clk); chk("t1_deq2", dq.outCtrl, 2);
        tick();
        @(negedge clk); chk("t1_deq3", dq.outCtrl, 3);
        tick();
        dq.outReady = 1'b0;
        @(negedge clk);
        chk("t1_empty", dq.outValid, 0);

        // 2: fill, hold inValid while full, then one dequeue
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            put(10 + i, 32'h300 + i, 32'h400 + i, 0, 0, 0, 0);
            tick();
        end
        put(99, 32'h999, 32'h999, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_full_rdy", dq.inReady, 0);
        tick();
        @(negedge clk);
        chk("t2_hold_count", dq.count, 4);
        tick();
        idle_in();
        dq.outReady = 1'b1;
        @(negedge clk);
        chk("t2_nobypass", dq.inReady, 0);
        tick();
        dq.outReady = 1'b0;
        @(negedge clk);
        chk("t2_rdy_after", dq.inReady, 1);
        chk("t2_count3", dq.count, 3);
        chk("t2_head", dq.outCtrl, 11);
        tick();
        dq.outReady = 1'b1;
        tick(); tick(); tick();
        dq.outReady = 1'b0;

        // 3: stored-entry snoop, non-matching tag, busy-clear operand ignores tag
        put(20, 32'h1111, 32'h2222, 1, 0, 5, 4); tick();
        idle_in();
        @(negedge clk);
        chk("t3_busy_before", dq.outBusy1, 1);
        tick();
        cdb(1, 4, 32'h4444);
        @(negedge clk);
        chk("t3_tag4_op1", dq.outOp1, 32'h1111);
        chk("t3_tag4_busy", dq.outBusy1, 1);
        chk("t3_tag4_op2", dq.outOp2, 32'h2222);
        tick();
        cdb(1, 5, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t3_fwd_op1", dq.outOp1, 32'hDEAD_BEEF);
        tick();
        cdb(0, 0, 0);
        @(negedge clk);
        chk("t3_stored_op1", dq.outOp1, 32'hDEAD_BEEF);
        chk("t3_stored_busy", dq.outBusy1, 0);
        tick();
        dq.outReady = 1'b1; tick(); dq.outReady = 1'b0;

        // 4: dispatch coinciding with the broadcast
        put(30, 32'h11, 32'h22, 1, 1, 6, 3); tick();
        idle_in();
        @(negedge clk);
        chk("t4_busy2_before", dq.outBusy2, 1);
        tick();
        cdb(1, 3, 32'h7);
        dq.outReady = 1'b1;
        @(negedge clk);
        chk("t4_op2", dq.outOp2, 7);
        chk("t4_busy2", dq.outBusy2, 0);
        chk("t4_busy1", dq.outBusy1, 1);
        tick();
        cdb(0, 0, 0);
        dq.outReady = 1'b0;

        // Write-port snoop
        put(31, 32'h33, 32'h44, 1, 0, 2, 0);
        cdb(1, 2, 32'hABC);
        tick();
        idle_in();
        cdb(0, 0, 0);
        @(negedge clk);
        chk("wr_snoop_op1", dq.outOp1, 32'hABC);
        chk("wr_snoop_busy", dq.outBusy1, 0);
        tick();
        dq.outReady = 1'b1; tick(); dq.outReady = 1'b0;

        // 5: flush with inValid, then reset mid-fill
        for (int i = 0; i < 3; i++) begin
            put(60 + i, 32'h600 + i, 32'h700 + i, 0, 0, 0, 0);
            tick();
        end
        put(77, 32'h77, 32'h77, 0, 0, 0, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_in();
        @(negedge clk);
        chk("t5_flush_count", dq.count, 0);
        chk("t5_flush_valid", dq.outValid, 0);
        chk("t5_flush_ctrl", dq.outCtrl, 0);
        tick();
        put(70, 1, 2, 0, 0, 0, 0); tick();
        put(71, 3, 4, 0, 0, 0, 0); tick();
        put(88, 5, 6, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_in();
        @(negedge clk);
        chk("t5_rst_count", dq.count, 0);
        chk("t5_rst_rdy", dq.inReady, 1);

        // 6: back-to-back enqueue and dequeue across pointer wrap
        tick();
        put(40, 32'h5000, 32'h6000, 0, 0, 0, 0); tick();
        put(41, 32'h5001, 32'h6001, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3 * DEPTH; i++) begin
            put(42 + i, 32'h5002 + i * 3, 32'h6002 + i * 5, 0, 0, 0, 0);
            dq.outReady = 1'b1;
            tick();
        end
        idle_in();
        dq.outReady = 1'b0;
        @(negedge clk);
        chk("t6_count", dq.count, 2);
        chk("t6_head", dq.outCtrl, 52);
        tick();
        dq.outReady = 1'b1;
        tick(); tick();
        dq.outReady = 1'b0;
        @(negedge clk);
        chk("t6_drained", dq.count, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
